// File: rtl/exception_unit.sv
// Exception sequencer for the Elpis pipeline: picks the oldest faulting stage,
// flushes the pipeline, emits a one-cycle rm0..rm2 record and handles iret.
module exception_unit #(
  parameter logic [31:0] HANDLER_PC    = 32'h0000_2000,
  parameter int unsigned FLUSH_CYCLES  = 2,
  parameter int unsigned CODE_ILLEGAL  = 1,
  parameter int unsigned CODE_ITLB     = 2,
  parameter int unsigned CODE_DTLB     = 3,
  parameter int unsigned CODE_MISALIGN = 4,
  parameter int unsigned CODE_PRIV     = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_itlb_miss,
  input  logic [31:0] if_pc,
  input  logic        id_illegal,
  input  logic        id_priv_instr,
  input  logic [31:0] id_pc,
  input  logic        mem_dtlb_miss,
  input  logic        mem_misaligned,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_addr,
  input  logic        psw_supervisor,
  input  logic        iret,
  input  logic [31:0] epc_in,
  output logic [31:0] out_rm0,
  output logic [31:0] out_rm1,
  output logic [31:0] out_rm2,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, FLUSH, COMMIT, RET} state_t;

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [31:0] rec_rm0, rec_rm1, rec_rm2;
  logic [31:0] rec_rm0_n, rec_rm1_n, rec_rm2_n;
  logic [31:0] epc_q, epc_n;
  logic        req_priv, any_req;

  logic        flush_n, redirect_valid_n, busy_n;
  logic [31:0] redirect_pc_n, out_rm0_n, out_rm1_n, out_rm2_n;

  assign req_priv = id_priv_instr & ~psw_supervisor;
  assign any_req  = mem_misaligned | mem_dtlb_miss | req_priv | id_illegal | if_itlb_miss;

  // Next-state logic; requests and iret are only looked at in IDLE, and the
  // oldest pipeline stage wins when several fault together.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rec_rm0_n = rec_rm0;
    rec_rm1_n = rec_rm1;
    rec_rm2_n = rec_rm2;
    epc_n     = epc_q;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_n = FLUSH;
          cnt_n   = 3'(FLUSH_CYCLES);
          if (mem_misaligned) begin
            rec_rm0_n = mem_pc;
            rec_rm1_n = mem_addr;
            rec_rm2_n = 32'(CODE_MISALIGN);
          end else if (mem_dtlb_miss) begin
            rec_rm0_n = mem_pc;
            rec_rm1_n = mem_addr;
            rec_rm2_n = 32'(CODE_DTLB);
          end else if (req_priv) begin
            rec_rm0_n = id_pc;
            rec_rm1_n = 32'h0;
            rec_rm2_n = 32'(CODE_PRIV);
          end else if (id_illegal) begin
            rec_rm0_n = id_pc;
            rec_rm1_n = 32'h0;
            rec_rm2_n = 32'(CODE_ILLEGAL);
          end else begin
            rec_rm0_n = if_pc;
            rec_rm1_n = if_pc;
            rec_rm2_n = 32'(CODE_ITLB);
          end
        end else if (iret) begin
          state_n = RET;
          epc_n   = epc_in;
        end
      end
      FLUSH: begin
        cnt_n = cnt - 3'd1;
        if (cnt <= 3'd1) state_n = COMMIT;
      end
      COMMIT:  state_n = IDLE;
      RET:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they can be registered and
  // line up exactly with the state they describe.
  always_comb begin
    flush_n          = (state_n != IDLE);
    busy_n           = (state_n != IDLE);
    redirect_valid_n = (state_n == COMMIT) || (state_n == RET);
    redirect_pc_n    = 32'h0;
    out_rm0_n        = 32'h0;
    out_rm1_n        = 32'h0;
    out_rm2_n        = 32'h0;
    if (state_n == COMMIT) begin
      redirect_pc_n = HANDLER_PC;
      out_rm0_n     = rec_rm0_n;
      out_rm1_n     = rec_rm1_n;
      out_rm2_n     = rec_rm2_n;
    end else if (state_n == RET) begin
      redirect_pc_n = epc_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 3'd0;
      rec_rm0        <= 32'h0;
      rec_rm1        <= 32'h0;
      rec_rm2        <= 32'h0;
      epc_q          <= 32'h0;
      flush          <= 1'b0;
      busy           <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
      out_rm0        <= 32'h0;
      out_rm1        <= 32'h0;
      out_rm2        <= 32'h0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      rec_rm0        <= rec_rm0_n;
      rec_rm1        <= rec_rm1_n;
      rec_rm2        <= rec_rm2_n;
      epc_q          <= epc_n;
      flush          <= flush_n;
      busy           <= busy_n;
      redirect_valid <= redirect_valid_n;
      redirect_pc    <= redirect_pc_n;
      out_rm0        <= out_rm0_n;
      out_rm1        <= out_rm1_n;
      out_rm2        <= out_rm2_n;
    end
  end

endmodule

// File: tb/tb_exception_unit.sv
// Directed self-checking bench for exception_unit with hand-computed expectations
// (default FLUSH_CYCLES = 2, HANDLER_PC = 0x2000).
module tb_exception_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_itlb_miss, id_illegal, id_priv_instr;
  logic        mem_dtlb_miss, mem_misaligned, psw_supervisor, iret;
  logic [31:0] if_pc, id_pc, mem_pc, mem_addr, epc_in;
  logic [31:0] out_rm0, out_rm1, out_rm2, redirect_pc;
  logic        flush, redirect_valid, busy;

  int checks = 0;
  int errors = 0;

  exception_unit dut (
    .clk(clk), .reset(reset),
    .if_itlb_miss(if_itlb_miss), .if_pc(if_pc),
    .id_illegal(id_illegal), .id_priv_instr(id_priv_instr), .id_pc(id_pc),
    .mem_dtlb_miss(mem_dtlb_miss), .mem_misaligned(mem_misaligned),
    .mem_pc(mem_pc), .mem_addr(mem_addr),
    .psw_supervisor(psw_supervisor), .iret(iret), .epc_in(epc_in),
    .out_rm0(out_rm0), .out_rm1(out_rm1), .out_rm2(out_rm2),
    .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Steps one clock and lands 1 ns after the edge, away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic mis, input logic dtlb, input logic priv,
                               input logic ill, input logic itlb, input logic ret);
    mem_misaligned = mis;
    mem_dtlb_miss  = dtlb;
    id_priv_instr  = priv;
    id_illegal     = ill;
    if_itlb_miss   = itlb;
    iret           = ret;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".flush"}, {31'h0, flush}, 32'h0);
    checkOutput({tag, ".busy"}, {31'h0, busy}, 32'h0);
    checkOutput({tag, ".rv"}, {31'h0, redirect_valid}, 32'h0);
    checkOutput({tag, ".rpc"}, redirect_pc, 32'h0);
    checkOutput({tag, ".rm0"}, out_rm0, 32'h0);
    checkOutput({tag, ".rm1"}, out_rm1, 32'h0);
    checkOutput({tag, ".rm2"}, out_rm2, 32'h0);
  endtask

  task automatic checkFlushing(input string tag);
    checkOutput({tag, ".flush"}, {31'h0, flush}, 32'h1);
    checkOutput({tag, ".busy"}, {31'h0, busy}, 32'h1);
    checkOutput({tag, ".rv"}, {31'h0, redirect_valid}, 32'h0);
    checkOutput({tag, ".rm2"}, out_rm2, 32'h0);
  endtask

  task automatic checkCommit(input string tag, input logic [31:0] rm0,
                             input logic [31:0] rm1, input logic [31:0] rm2);
    checkOutput({tag, ".flush"}, {31'h0, flush}, 32'h1);
    checkOutput({tag, ".busy"}, {31'h0, busy}, 32'h1);
    checkOutput({tag, ".rv"}, {31'h0, redirect_valid}, 32'h1);
    checkOutput({tag, ".rpc"}, redirect_pc, 32'h0000_2000);
    checkOutput({tag, ".rm0"}, out_rm0, rm0);
    checkOutput({tag, ".rm1"}, out_rm1, rm1);
    checkOutput({tag, ".rm2"}, out_rm2, rm2);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    psw_supervisor = 1'b0;
    if_pc = 32'h0; id_pc = 32'h0; mem_pc = 32'h0; mem_addr = 32'h0; epc_in = 32'h0;

    // Reset held two cycles, then ten quiet cycles
    tick(); tick();
    checkIdle("reset");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("quiet.rm2", out_rm2, 32'h0);
      checkOutput("quiet.busy", {31'h0, busy}, 32'h0);
    end

    // DTLB miss: flush N+1..N+2, record at N+3, then idle
    mem_pc = 32'h100; mem_addr = 32'hABC0;
    applyStimulus(0, 1, 0, 0, 0, 0);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0);
    checkFlushing("dtlb.n1");
    tick(); checkFlushing("dtlb.n2");
    tick(); checkCommit("dtlb.n3", 32'h100, 32'hABC0, 32'd3);
    tick(); checkIdle("dtlb.n4");

    // Misaligned beats illegal and ITLB in the same cycle
    mem_pc = 32'h200; mem_addr = 32'h203; id_pc = 32'h204; if_pc = 32'h208;
    applyStimulus(1, 0, 0, 1, 1, 0);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0);
    checkFlushing("prio.n1");
    tick(); checkFlushing("prio.n2");
    tick(); checkCommit("prio.n3", 32'h200, 32'h203, 32'd4);
    for (int i = 0; i < 4; i++) begin
      tick(); checkIdle("prio.after");
    end

    // Privileged instruction in supervisor mode is not an exception
    psw_supervisor = 1'b1; id_pc = 32'h40;
    applyStimulus(0, 0, 1, 0, 0, 0);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0);
    checkIdle("priv_sup.n1");
    tick(); checkIdle("priv_sup.n2");

    // Same in user mode raises a privilege fault
    psw_supervisor = 1'b0;
    applyStimulus(0, 0, 1, 0, 0, 0);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0);
    checkFlushing("priv_usr.n1");
    tick(); tick(); checkCommit("priv_usr.n3", 32'h40, 32'h0, 32'd5);
    tick(); checkIdle("priv_usr.n4");

    // iret redirects to epc as sampled on entry
    epc_in = 32'h1234;
    applyStimulus(0, 0, 0, 0, 0, 1);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0);
    epc_in = 32'h5555;
    checkOutput("iret.rv", {31'h0, redirect_valid}, 32'h1);
    checkOutput("iret.rpc", redirect_pc, 32'h1234);
    checkOutput("iret.flush", {31'h0, flush}, 32'h1);
    checkOutput("iret.busy", {31'h0, busy}, 32'h1);
    checkOutput("iret.rm2", out_rm2, 32'h0);
    tick(); checkIdle("iret.n2");

    // iret together with ITLB miss: only the exception path is taken
    if_pc = 32'h300;
    applyStimulus(0, 0, 0, 0, 1, 1);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0);
    checkFlushing("iret_itlb.n1");
    tick(); checkFlushing("iret_itlb.n2");
    tick(); checkCommit("iret_itlb.n3", 32'h300, 32'h300, 32'd2);
    tick(); checkIdle("iret_itlb.n4");

    // Reset during FLUSH aborts without any record
    mem_pc = 32'h500; mem_addr = 32'h504;
    applyStimulus(0, 1, 0, 0, 0, 0);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0);
    checkFlushing("rst_flush.n1");
    reset = 1'b1;
    tick(); checkIdle("rst_flush.n2");
    reset = 1'b0;
    tick(); checkIdle("rst_flush.n3");
    tick(); checkIdle("rst_flush.n4");

    // Requests and iret while busy are ignored; record stays the first one
    mem_pc = 32'h100; mem_addr = 32'hABC0;
    applyStimulus(0, 1, 0, 0, 0, 0);
    tick();
    mem_pc = 32'h999; mem_addr = 32'h777; id_pc = 32'h888; if_pc = 32'h666; epc_in = 32'h4444;
    applyStimulus(1, 0, 0, 1, 1, 1);
    checkFlushing("busy_req.n1");
    tick(); checkFlushing("busy_req.n2");
    tick(); applyStimulus(0, 0, 0, 0, 0, 0);
    checkCommit("busy_req.n3", 32'h100, 32'hABC0, 32'd3);
    tick(); checkIdle("busy_req.n4");
    tick(); checkIdle("busy_req.n5");

    // Back-to-back: request in the IDLE cycle right after COMMIT is taken
    mem_pc = 32'h600; mem_addr = 32'h601;
    applyStimulus(0, 1, 0, 0, 0, 0);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0);
    tick(); tick(); checkCommit("b2b.first", 32'h600, 32'h601, 32'd3);
    tick();
    checkIdle("b2b.idle");
    if_pc = 32'h700;
    applyStimulus(0, 0, 0, 0, 1, 0);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0);
    checkFlushing("b2b.n1");
    tick(); tick(); checkCommit("b2b.second", 32'h700, 32'h700, 32'd2);
    tick(); checkIdle("b2b.end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
